alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle unsigned 64×64 multiply sequencer that drives the shared `alu` through a shift-and-add loop and returns the low 64 bits of the product plus an exact overflow flag. It sits between the execute-stage issue logic and the ALU's operand/enable inputs. It owns the ALU only while an external arbiter grants it. It terminates early once the remaining multiplier bits are zero.

## Interface
Parameters: none; the width is fixed at 64.

- `clk_i` input 1: the single clock. All state changes on the rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `start_i` input 1: request a multiply. Sampled only in IDLE.
- `a_i` input 64: multiplicand, captured on accept.
- `b_i` input 64: multiplier, captured on accept.
- `busy_o` output 1: high in any state other than IDLE.
- `valid_o` output 1: result available. High only in DONE.
- `ack_i` input 1: consumer takes the result. Meaningful only while `valid_o` is high.
- `product_o` output 64: low 64 bits of a×b. Stable while `valid_o` is high.
- `ovf_o` output 1: true product ≥ 2^64. Stable while `valid_o` is high.
- `alu_req_o` output 1: request the ALU from the arbiter. High in STEP.
- `alu_gnt_i` input 1: ALU granted this cycle.
- `alu_a_o` output 64: to ALU `inA_i`.
- `alu_b_o` output 64: to ALU `inB_i`.
- `alu_cflag_o` output 1: to ALU `cflag_i`. Always 0.
- `alu_sum_en_o`, `alu_and_en_o`, `alu_xor_en_o` output 1 each: ALU function enables.
- `alu_out_i` input 64: from ALU `out_o`.
- `alu_cflag_i` input 1: from ALU `cflag_o`.

## Operation
- Registers:
  - `state` ∈ {IDLE, STEP, DONE}
  - `mcand` (64)
  - `mplier` (64)
  - `acc` (64)
  - `ovf` (1)
- Reset (async, `reset_ni`=0): `state`=IDLE and all registers are 0. The resulting outputs are:
  - `busy_o`=0, `valid_o`=0, `alu_req_o`=0
  - `product_o`=0, `ovf_o`=0
  - ALU enables all 0; `alu_a_o`=`alu_b_o`=0.
- IDLE:
  - If `start_i`=1: `mcand`←`a_i`, `mplier`←`b_i`, `acc`←0, `ovf`←0, then go to STEP.
  - Otherwise stay in IDLE.
- STEP:
  - `alu_req_o`=1.
  - ALU drive: `alu_a_o`=`acc`, `alu_b_o`=`mplier[0]` ? `mcand` : 0, `alu_sum_en_o`=1, and/xor enables 0, `alu_cflag_o`=0.
  - `alu_gnt_i`=0: no register changes. Operand outputs stay as defined (stall).
  - `alu_gnt_i`=1, in one edge:
    - `acc`←`alu_out_i`.
    - `ovf`←`ovf` | (`mplier[0]` & `alu_cflag_i`) | (`mcand[63]` & (`mplier[63:1]`≠0)).
    - `mcand`←`mcand`<<1.
    - `mplier`←`mplier`>>1.
    - If `mplier[63:1]`=0, go to DONE; otherwise stay in STEP.
- DONE:
  - `valid_o`=1; `product_o`=`acc`, `ovf_o`=`ovf`.
  - `ack_i`=1: go to IDLE.
  - `start_i` in the same cycle is ignored. A new request is accepted at the earliest on the following cycle.
- Outside STEP: every ALU enable and `alu_req_o` is 0, and `alu_a_o`/`alu_b_o` are driven as 0.
- `product_o`/`ovf_o` always reflect `acc`/`ovf`. Consumers use them only when `valid_o`=1.
- `b_i`=0: exactly one STEP is executed (adds 0), giving product 0 and ovf 0.

## Timing
- Accept edge: E0.
- Granted STEP cycles: N = max(1, msb_index(b)+1), so 1..64.
- With continuous grant, `valid_o` rises N cycles after E0. It is first visible in cycle E0+N+1, counting E0 as cycle 0's edge.
- Each cycle with `alu_gnt_i`=0 in STEP adds exactly one cycle of latency.
- `valid_o` stays high, with outputs held, until the edge where `ack_i`=1. `busy_o` falls on that same edge.
- Back-to-back throughput: one result per N+2 cycles (accept, N steps, DONE/ack).
- `reset_ni` asserted mid-STEP or in DONE: all outputs go to reset values immediately (asynchronously). Any in-flight result is discarded. No partial result is ever presented.
- Grant may drop at any STEP cycle, including the last. Results must be identical with or without stalls.

## Test plan
- `a`=3, `b`=5, grant held high → 3 STEP cycles; `valid_o` with `product_o`=15, `ovf_o`=0; `alu_req_o` high for exactly 3 cycles.
- `a`=0x1234, `b`=0 → 1 STEP; `product_o`=0, `ovf_o`=0; latency 1 step.
- `a`=0x8000_0000_0000_0000, `b`=2 → `product_o`=0, `ovf_o`=1 (from the shift-out term). Then `a`=0x8000_0000_0000_0000, `b`=1 → product 0x8000_0000_0000_0000, `ovf_o`=0.
- `a`=`b`=0xFFFF_FFFF_FFFF_FFFF → 64 STEP cycles; `product_o`=1, `ovf_o`=1. Also `a`=`b`=2^32 → product 0, ovf 1. Also `a`=`b`=2^32−1 → product 0xFFFF_FFFE_0000_0001, ovf 0.
- `a`=7, `b`=9 with `alu_gnt_i` toggling 0/1 each cycle → `product_o`=63; latency = 4 granted + 4 stalled steps; ALU outputs stable across stalls.
- Reset and handshake corner cases:
  - Pull `reset_ni` low mid-way through a 64-step multiply → `busy_o`=0, `valid_o`=0, `product_o`=0 immediately.
  - After release, `start_i` with 6×7 → 42.
  - Assert `start_i` with `ack_i` in DONE → second request not accepted until the next cycle.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential unsigned 64x64 multiplier that borrows the shared ALU adder.
// Shift-and-add: each granted step adds the (optionally masked) multiplicand
// into the accumulator, then shifts the multiplicand left and the multiplier
// right. The loop ends as soon as no multiplier bits remain, so small
// multipliers finish in fewer steps.
//
// state | meaning
// IDLE  | waiting for start_i; operands captured on accept
// STEP  | ALU requested; one shift-and-add per granted cycle
// DONE  | result presented on product_o/ovf_o until ack_i
module alu_mul_seq (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        busy_o,
  output logic        valid_o,
  input  logic        ack_i,
  output logic [63:0] product_o,
  output logic        ovf_o,
  output logic        alu_req_o,
  input  logic        alu_gnt_i,
  output logic [63:0] alu_a_o,
  output logic [63:0] alu_b_o,
  output logic        alu_cflag_o,
  output logic        alu_sum_en_o,
  output logic        alu_and_en_o,
  output logic        alu_xor_en_o,
  input  logic [63:0] alu_out_i,
  input  logic        alu_cflag_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic [63:0] acc;
  logic        ovf;

  // Bits of the multiplier still to be consumed after the current step.
  logic        more_bits;
  assign more_bits = (mplier[63:1] != 63'd0);

  // Sequencer: operand capture, one add/shift per grant, result handshake.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= ST_IDLE;
      mcand  <= 64'd0;
      mplier <= 64'd0;
      acc    <= 64'd0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            mcand  <= a_i;
            mplier <= b_i;
            acc    <= 64'd0;
            ovf    <= 1'b0;
            state  <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (alu_gnt_i) begin
            acc    <= alu_out_i;
            // Overflow if this add carried out, or if a set multiplicand bit
            // is about to be shifted out while multiplier bits remain.
            ovf    <= ovf | (mplier[0] & alu_cflag_i) | (mcand[63] & more_bits);
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[63:1]};
            if (!more_bits) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // A start_i in the same cycle as ack_i is deliberately not taken here;
          // the request is seen in IDLE on the next cycle.
          if (ack_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic in_step;
  assign in_step = (state == ST_STEP);

  // Status and result outputs decoded purely from registers.
  always_comb begin
    busy_o    = (state != ST_IDLE);
    valid_o   = (state == ST_DONE);
    product_o = acc;
    ovf_o     = ovf;
  end

  // ALU drive; everything is forced to zero outside STEP so the shared ALU
  // sees a quiet port whenever this block does not own it.
  always_comb begin
    alu_req_o    = in_step;
    alu_sum_en_o = in_step;
    alu_and_en_o = 1'b0;
    alu_xor_en_o = 1'b0;
    alu_cflag_o  = 1'b0;
    alu_a_o      = in_step ? acc : 64'd0;
    alu_b_o      = (in_step && mplier[0]) ? mcand : 64'd0;
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized bench for alu_mul_seq with a behavioural ALU and a 128-bit
// arithmetic reference for product, overflow and step count.
module tb_alu_mul_seq;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        busy_o;
  logic        valid_o;
  logic        ack_i = 1'b0;
  logic [63:0] product_o;
  logic        ovf_o;
  logic        alu_req_o;
  logic        alu_gnt_i = 1'b0;
  logic [63:0] alu_a_o;
  logic [63:0] alu_b_o;
  logic        alu_cflag_o;
  logic        alu_sum_en_o;
  logic        alu_and_en_o;
  logic        alu_xor_en_o;
  logic [63:0] alu_out_i;
  logic        alu_cflag_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  alu_mul_seq dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .start_i      (start_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .product_o    (product_o),
    .ovf_o        (ovf_o),
    .alu_req_o    (alu_req_o),
    .alu_gnt_i    (alu_gnt_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_cflag_o  (alu_cflag_o),
    .alu_sum_en_o (alu_sum_en_o),
    .alu_and_en_o (alu_and_en_o),
    .alu_xor_en_o (alu_xor_en_o),
    .alu_out_i    (alu_out_i),
    .alu_cflag_i  (alu_cflag_i)
  );

  // Behavioural shared ALU: add with carry in/out, plus bitwise functions.
  logic [64:0] alu_full;
  always_comb begin
    alu_full = 65'd0;
    if (alu_sum_en_o)
      alu_full = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {64'd0, alu_cflag_o};
    else if (alu_and_en_o)
      alu_full = {1'b0, alu_a_o & alu_b_o};
    else if (alu_xor_en_o)
      alu_full = {1'b0, alu_a_o ^ alu_b_o};
  end
  assign alu_out_i   = alu_full[63:0];
  assign alu_cflag_i = alu_full[64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_steps(input logic [63:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Pulse start_i for one accept edge; returns at the negedge after it.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk_i);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Called at the negedge just after the accept edge. gmode: 0 always grant,
  // 1 alternate starting with a stall, 2 random grant.
  task automatic finish_op(input logic [63:0] a, input logic [63:0] b, input int gmode,
                           input string tag);
    logic [127:0] full;
    int n_exp, granted, stalls, reqs, lat, stab_bad, drive_bad;
    logic stalled_prev;
    logic [63:0] sa, sb;
    logic g;
    full = {64'd0, a} * {64'd0, b};
    n_exp = exp_steps(b);
    granted = 0; stalls = 0; reqs = 0; lat = 0;
    stab_bad = 0; drive_bad = 0;
    stalled_prev = 1'b0;
    sa = '0; sb = '0;
    while (!valid_o && lat < 400) begin
      if (alu_req_o) begin
        reqs++;
        if (stalled_prev && (alu_a_o !== sa || alu_b_o !== sb)) stab_bad++;
        if (alu_sum_en_o !== 1'b1 || alu_cflag_o !== 1'b0 || alu_and_en_o || alu_xor_en_o)
          drive_bad++;
        case (gmode)
          0: g = 1'b1;
          1: g = stalled_prev;
          default: g = 1'($urandom_range(0, 1));
        endcase
        alu_gnt_i = g;
        if (g) granted++; else stalls++;
        stalled_prev = !g;
        sa = alu_a_o;
        sb = alu_b_o;
      end else begin
        alu_gnt_i = 1'b0;
        stalled_prev = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    alu_gnt_i = 1'b0;
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_product"}, product_o, full[63:0]);
    check({tag, "_ovf"}, 64'(ovf_o), 64'(full[127:64] != 64'd0));
    check({tag, "_granted"}, 64'(granted), 64'(n_exp));
    check({tag, "_req_cycles"}, 64'(reqs), 64'(n_exp + stalls));
    check({tag, "_latency"}, 64'(lat), 64'(n_exp + stalls));
    check({tag, "_stall_stable"}, 64'(stab_bad), 64'd0);
    check({tag, "_alu_drive"}, 64'(drive_bad), 64'd0);
    // Result must hold while unacknowledged.
    @(negedge clk_i);
    check({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_hold_prod"}, product_o, full[63:0]);
    check({tag, "_done_req"}, 64'(alu_req_o), 64'd0);
  endtask

  task automatic ack_op(input string tag);
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    check({tag, "_ack_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_ack_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int gmode,
                        input string tag);
    start_op(a, b);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    finish_op(a, b, gmode, tag);
    ack_op(tag);
  endtask

  initial begin
    logic [63:0] ra, rb;
    // Reset state.
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_req", 64'(alu_req_o), 64'd0);
    check("rst_product", product_o, 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_alu_a", alu_a_o, 64'd0);
    check("rst_alu_b", alu_b_o, 64'd0);
    check("rst_sum_en", 64'(alu_sum_en_o), 64'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Directed cases.
    run_op(64'd3, 64'd5, 0, "d3x5");
    run_op(64'h1234, 64'd0, 0, "dbzero");
    run_op(64'h8000_0000_0000_0000, 64'd2, 0, "dmsb_x2");
    run_op(64'h8000_0000_0000_0000, 64'd1, 0, "dmsb_x1");
    run_op('1, '1, 0, "dones");
    run_op(64'h1_0000_0000, 64'h1_0000_0000, 0, "d2p32");
    run_op(64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, "d2p32m1");
    run_op(64'd7, 64'd9, 1, "d7x9_toggle");
    run_op('1, '1, 2, "dones_rand");

    // Reset in the middle of a long multiply.
    start_op('1, '1);
    alu_gnt_i = 1'b1;
    repeat (20) @(negedge clk_i);
    reset_ni = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_product", product_o, 64'd0);
    check("midrst_req", 64'(alu_req_o), 64'd0);
    alu_gnt_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    run_op(64'd6, 64'd7, 0, "post_rst");

    // start_i together with ack_i in DONE must not be accepted that cycle.
    start_op(64'd11, 64'd13);
    finish_op(64'd11, 64'd13, 0, "hs_first");
    a_i = 64'd6;
    b_i = 64'd7;
    start_i = 1'b1;
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    check("hs_not_taken_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    check("hs_next_taken_busy", 64'(busy_o), 64'd1);
    finish_op(64'd6, 64'd7, 0, "hs_second");
    ack_op("hs_second");

    // Randomized operands with varied multiplier width and grant patterns.
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rb = rb >> $urandom_range(0, 63);
      if (i % 5 == 0) ra = ra >> $urandom_range(0, 63);
      run_op(ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
